// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the memory port arbiter, its two requesters and the memory.
// slave = arbiter side, master = requester/memory side.
interface mem_port_arbiter_if #(
  parameter int AW = 64,
  parameter int DW = 64
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic [DW-1:0] if_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          sel;
  logic          busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_ack, if_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata, sel, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_ack, if_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata, sel, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares the unified memory port between instruction fetch and load/store.
// Optional MEM_ARB_STARVE_EN: forces a fetch grant after STARVE_MAX contested data grants.
module mem_port_arbiter #(
  parameter int AW         = 64,
  parameter int DW         = 64,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  if (MEM_LAT < 1 || MEM_LAT > 15 || STARVE_MAX < 1) begin : g_param_check
    $error("mem_port_arbiter: MEM_LAT must be 1..15 and STARVE_MAX at least 1");
  end

  state_t        r_state;
  logic [3:0]    r_cnt;
  logic          r_sel;
  logic          r_we;
  logic          r_mem_en;
  logic          r_mem_we;
  logic          r_if_ack;
  logic          r_d_ack;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_if_rdata;
  logic [DW-1:0] r_d_rdata;
  logic          w_req_any;
  logic          w_grant_d;

  assign w_req_any = bus.if_req | bus.d_req;

`ifdef MEM_ARB_STARVE_EN
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  logic [SW-1:0] r_starve;

  // A saturated count hands the next contested arbitration to fetch.
  assign w_grant_d = bus.d_req & ~(bus.if_req & (r_starve == SMAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve <= '0;
    end else if (r_state == IDLE && w_req_any) begin
      if (w_grant_d && bus.if_req) begin
        if (r_starve != SMAX) r_starve <= r_starve + 1'b1;
      end else begin
        r_starve <= '0;
      end
    end
  end
`else
  assign w_grant_d = bus.d_req;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_sel      <= 1'b0;
      r_we       <= 1'b0;
      r_mem_en   <= 1'b0;
      r_mem_we   <= 1'b0;
      r_if_ack   <= 1'b0;
      r_d_ack    <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_req_any) begin
            r_state  <= ISSUE;
            r_sel    <= w_grant_d;
            r_addr   <= w_grant_d ? bus.d_addr : bus.if_addr;
            r_we     <= w_grant_d & bus.d_we;
            r_mem_we <= w_grant_d & bus.d_we;
            r_mem_en <= 1'b1;
            if (w_grant_d) r_wdata <= bus.d_wdata;
          end
        end
        ISSUE: begin
          r_state  <= WAIT;
          r_mem_en <= 1'b0;
          r_mem_we <= 1'b0;
          r_cnt    <= LAT_M1;
        end
        WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= DONE;
            // Writes leave both read-data registers untouched.
            if (!r_we) begin
              if (r_sel) r_d_rdata  <= bus.mem_rdata;
              else       r_if_rdata <= bus.mem_rdata;
            end
            if (r_sel) r_d_ack  <= 1'b1;
            else       r_if_ack <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        DONE: begin
          r_state  <= IDLE;
          r_if_ack <= 1'b0;
          r_d_ack  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.mem_en    = r_mem_en;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.sel       = r_sel;
  assign bus.busy      = (r_state != IDLE);
  assign bus.if_ack    = r_if_ack;
  assign bus.d_ack     = r_d_ack;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.d_rdata   = r_d_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-timeline reference model checked every cycle,
// directed scenarios with literal expectations, then randomized requester traffic.
module tb_mem_port_arbiter;
  localparam int LAT  = 2;
  localparam int SMAX = 4;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  mem_port_arbiter_if #(.AW(64), .DW(64)) bus ();

  mem_port_arbiter #(.AW(64), .DW(64), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference model: one transfer per grant, laid out on a cycle timeline from its grant cycle t.
  longint      cyc = 0;
  bit          m_act = 0;
  longint      m_t = 0;
  bit          m_own, m_we;
  logic [63:0] m_addr, m_wd, m_cap;
  int          m_starve = 0;
  bit          e_sel = 0;
  logic [63:0] e_addr = '0, e_wdata = '0, e_ifr = '0, e_dr = '0;
  bit          seen_if_ack = 0, seen_d_ack = 0;

  always @(negedge clk) begin
    bit x_en, x_busy, x_ack, contested;
    cyc++;
    if (!rst_n) begin
      m_act = 0; m_starve = 0; e_sel = 0;
      e_addr = '0; e_wdata = '0; e_ifr = '0; e_dr = '0;
      seen_if_ack = 0; seen_d_ack = 0;
      chk("rst_busy", bus.busy, 0);
      chk("rst_acks", {bus.if_ack, bus.d_ack}, 0);
      chk("rst_mem_en", bus.mem_en, 0);
    end else begin
      if (m_act && cyc == m_t + 1) begin
        e_sel = m_own; e_addr = m_addr;
        if (m_own) e_wdata = m_wd;
      end
      if (m_act && cyc == m_t + 2 + LAT && !m_we) begin
        if (m_own) e_dr = m_cap; else e_ifr = m_cap;
      end
      x_en   = m_act && (cyc == m_t + 1);
      x_busy = m_act && (cyc > m_t) && (cyc <= m_t + 2 + LAT);
      x_ack  = m_act && (cyc == m_t + 2 + LAT);
      chk("mem_en", bus.mem_en, x_en);
      chk("mem_we", bus.mem_we, x_en && m_we);
      chk("mem_addr", bus.mem_addr, e_addr);
      chk("mem_wdata", bus.mem_wdata, e_wdata);
      chk("sel", bus.sel, e_sel);
      chk("busy", bus.busy, x_busy);
      chk("if_ack", bus.if_ack, x_ack && !m_own);
      chk("d_ack", bus.d_ack, x_ack && m_own);
      chk("if_rdata", bus.if_rdata, e_ifr);
      chk("d_rdata", bus.d_rdata, e_dr);
      if (m_act && cyc == m_t + 1 + LAT) m_cap = bus.mem_rdata;
      seen_if_ack = bus.if_ack;
      seen_d_ack  = bus.d_ack;
      if (!x_busy && (bus.if_req || bus.d_req)) begin
        contested = bus.if_req && bus.d_req;
`ifdef MEM_ARB_STARVE_EN
        m_own = bus.d_req && !(contested && m_starve >= SMAX);
        if (m_own && bus.if_req) m_starve = (m_starve < SMAX) ? m_starve + 1 : SMAX;
        else m_starve = 0;
`else
        m_own = bus.d_req;
`endif
        m_act  = 1;
        m_t    = cyc;
        m_we   = m_own ? bus.d_we : 1'b0;
        m_addr = m_own ? bus.d_addr : bus.if_addr;
        m_wd   = bus.d_wdata;
      end
    end
  end

  task automatic go(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((bus.if_req || bus.d_req) && n < 200) begin
      go(1); n++;
      if (seen_if_ack) bus.if_req = 1'b0;
      if (seen_d_ack)  bus.d_req  = 1'b0;
    end
    chk("drain_timeout", {bus.if_req, bus.d_req}, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] got;
    logic [9:0] exp_order;
    int gi, n;
    rst_n = 1'b1;
    bus.if_req = 0; bus.if_addr = '0; bus.d_req = 0; bus.d_we = 0;
    bus.d_addr = '0; bus.d_wdata = '0; bus.mem_rdata = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", bus.busy, 0);
    chk("reset_sel", bus.sel, 0);
    chk("reset_if_rdata", bus.if_rdata, 0);
    chk("reset_d_rdata", bus.d_rdata, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single fetch read
    go(1); bus.if_req = 1; bus.if_addr = 64'h100; bus.mem_rdata = 64'h1111;
    go(1); @(negedge clk);
    chk("t1_mem_en", bus.mem_en, 1); chk("t1_mem_we", bus.mem_we, 0);
    chk("t1_mem_addr", bus.mem_addr, 64'h100); chk("t1_sel", bus.sel, 0);
    go(1); go(1); bus.mem_rdata = 64'hDEADBEEF;
    go(1); @(negedge clk);
    chk("t1_if_ack", bus.if_ack, 1); chk("t1_if_rdata", bus.if_rdata, 64'hDEADBEEF);
    go(1); bus.if_req = 0;

    // Contested: data first, then fetch
    go(1); bus.if_req = 1; bus.if_addr = 64'h300; bus.d_req = 1; bus.d_we = 0; bus.d_addr = 64'h400;
    go(1); @(negedge clk);
    chk("t2_sel", bus.sel, 1); chk("t2_mem_en", bus.mem_en, 1); chk("t2_mem_addr", bus.mem_addr, 64'h400);
    go(1); go(1); bus.mem_rdata = 64'hCAFE;
    go(1); @(negedge clk);
    chk("t2_d_ack", bus.d_ack, 1); chk("t2_if_ack_excl", bus.if_ack, 0); chk("t2_d_rdata", bus.d_rdata, 64'hCAFE);
    go(1); bus.d_req = 0;
    go(1); @(negedge clk);
    chk("t2_f_mem_en", bus.mem_en, 1); chk("t2_f_sel", bus.sel, 0); chk("t2_f_addr", bus.mem_addr, 64'h300);
    go(1); go(1); bus.mem_rdata = 64'hF00D;
    go(1); @(negedge clk);
    chk("t2_if_ack", bus.if_ack, 1); chk("t2_if_rdata", bus.if_rdata, 64'hF00D);
    go(1); bus.if_req = 0;

    // Data write: read-data registers must not move
    go(1); bus.d_req = 1; bus.d_we = 1; bus.d_addr = 64'h2000; bus.d_wdata = 64'h1234;
    go(1); @(negedge clk);
    chk("t3_mem_en", bus.mem_en, 1); chk("t3_mem_we", bus.mem_we, 1);
    chk("t3_mem_wdata", bus.mem_wdata, 64'h1234); chk("t3_mem_addr", bus.mem_addr, 64'h2000);
    go(1); go(1); bus.mem_rdata = 64'h5555; @(negedge clk);
    chk("t3_no_early_ack", bus.d_ack, 0);
    go(1); @(negedge clk);
    chk("t3_d_ack", bus.d_ack, 1); chk("t3_d_rdata_held", bus.d_rdata, 64'hCAFE);
    go(1); bus.d_req = 0; bus.d_we = 0;

    // Address changed after grant; request held through DONE then dropped
    go(1); bus.d_req = 1; bus.d_addr = 64'h40;
    go(1); go(1); bus.d_addr = 64'h80; @(negedge clk);
    chk("t6_addr_latched", bus.mem_addr, 64'h40);
    go(1); go(1); @(negedge clk);
    chk("t6_d_ack", bus.d_ack, 1);
    go(1); bus.d_req = 0; @(negedge clk);
    chk("t6_idle", bus.busy, 0);
    go(1); @(negedge clk);
    chk("t6_no_restart", bus.mem_en, 0); chk("t6_addr_held", bus.mem_addr, 64'h40);

    // Both requests held: grant order over 10 grants
    go(1); bus.if_req = 1; bus.if_addr = 64'h700; bus.d_req = 1; bus.d_we = 0; bus.d_addr = 64'h800;
    got = '0; gi = 0; n = 0;
    while (gi < 10 && n < 200) begin
      @(negedge clk); n++;
      if (bus.mem_en) begin got[gi] = bus.sel; gi++; end
    end
`ifdef MEM_ARB_STARVE_EN
    exp_order = 10'b0111101111;
`else
    exp_order = 10'b1111111111;
`endif
    chk("t4_grant_order", got, exp_order);
    drain();

    // Reset during WAIT aborts the transfer; next request completes normally
    go(1); bus.d_req = 1; bus.d_addr = 64'h500;
    go(1); go(1); rst_n = 0; bus.d_req = 0; #1;
    chk("t5_busy", bus.busy, 0); chk("t5_sel", bus.sel, 0); chk("t5_mem_addr", bus.mem_addr, 0);
    chk("t5_mem_wdata", bus.mem_wdata, 0); chk("t5_d_rdata", bus.d_rdata, 0);
    chk("t5_if_rdata", bus.if_rdata, 0); chk("t5_acks", {bus.if_ack, bus.d_ack}, 0);
    go(1); rst_n = 1;
    go(1); bus.d_req = 1; bus.d_addr = 64'h600;
    go(1); @(negedge clk);
    chk("t5_mem_en", bus.mem_en, 1); chk("t5_addr", bus.mem_addr, 64'h600);
    go(1); go(1); bus.mem_rdata = 64'hABCD;
    go(1); @(negedge clk);
    chk("t5_d_ack", bus.d_ack, 1); chk("t5_rdata", bus.d_rdata, 64'hABCD);
    go(1); bus.d_req = 0;

    // Randomized requester traffic
    for (int k = 0; k < 1500; k++) begin
      go(1);
      bus.mem_rdata = {$urandom, $urandom};
      if (bus.if_req && seen_if_ack) begin
        if ($urandom_range(2) == 0) bus.if_addr = {$urandom, $urandom};
        else bus.if_req = 0;
      end else if (!bus.if_req && $urandom_range(3) == 0) begin
        bus.if_req = 1; bus.if_addr = {$urandom, $urandom};
      end
      if (bus.d_req && seen_d_ack) begin
        if ($urandom_range(2) == 0) begin
          bus.d_addr = {$urandom, $urandom}; bus.d_we = 1'($urandom_range(1));
          bus.d_wdata = {$urandom, $urandom};
        end else bus.d_req = 0;
      end else if (!bus.d_req && $urandom_range(3) == 0) begin
        bus.d_req = 1; bus.d_addr = {$urandom, $urandom};
        bus.d_we = 1'($urandom_range(1)); bus.d_wdata = {$urandom, $urandom};
      end
      if (bus.busy && $urandom_range(4) == 0) begin
        bus.if_addr = {$urandom, $urandom}; bus.d_addr = {$urandom, $urandom};
        bus.d_wdata = {$urandom, $urandom};
      end
    end
    drain();
    go(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single unified memory port of the uPOWER multi-cycle core between the instruction-fetch requester and the load/store requester. It grants one requester at a time and latches that requester's address, write data and write enable. It drives the memory port and the datapath's 2:1 owner-select line, and returns read data with a one-cycle acknowledge. It sits between the fetch/LSU control and the memory, and replaces the ad-hoc select logic around the 64-bit address mux.

## Interface
- `AW`, 64, address width
- `DW`, 64, data width
- `MEM_LAT`, 2, cycles from the `mem_en` cycle to valid `mem_rdata`; legal range 1..15
- `STARVE_MAX`, 4, consecutive contested data grants before fetch is forced (used only with the macro)

Ports:
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `if_req`  in  1  fetch request, level, held until `if_ack`
- `if_addr`  in  AW  fetch address
- `if_ack`  out  1  one-cycle completion pulse to fetch
- `if_rdata`  out  DW  registered fetch read data
- `d_req`  in  1  data request, level, held until `d_ack`
- `d_we`  in  1  1 = write, 0 = read
- `d_addr`  in  AW  data address
- `d_wdata`  in  DW  write data
- `d_ack`  out  1  one-cycle completion pulse to data
- `d_rdata`  out  DW  registered data read data
- `mem_en`  out  1  memory access strobe, one cycle per transfer
- `mem_we`  out  1  memory write enable, valid with `mem_en`
- `mem_addr`  out  AW  latched address
- `mem_wdata`  out  DW  latched write data
- `mem_rdata`  in  DW  memory read data
- `sel`  out  1  current owner: 0 = fetch, 1 = data; drives the datapath 2:1 select
- `busy`  out  1  high whenever state is not IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE -> ISSUE when either request is high. At this edge the arbiter:
  - picks the owner;
  - sets `sel`;
  - latches the owner's address, write data (data owner only) and `d_we` (0 for fetch).
- Arbitration: data has priority over fetch.
- ISSUE: lasts one cycle; `mem_en`=1 and `mem_we`=latched we. -> WAIT, with the counter loaded with `MEM_LAT`-1.
- WAIT: lasts exactly `MEM_LAT` cycles; the counter decrements each cycle.
  - When the counter is 0, go to DONE.
  - On that edge, a read captures `mem_rdata` into the owner's rdata register.
  - A write captures nothing; the rdata registers hold their values.
- DONE: lasts one cycle; the owner's ack = 1. -> IDLE unconditionally.
- Requests seen during DONE are ignored.
- Requester rule: drop req in the cycle after ack unless a new request is wanted. A req seen in IDLE is always a new transfer.
- `mem_addr`/`mem_wdata` are registered and hold their values after the transfer. Changes to requester inputs after the grant have no effect.
- `sel` holds the last owner while IDLE.
- Reset (async, any state): state IDLE; all outputs 0, including `sel`, `if_rdata`, `d_rdata` and the acks; counter and starvation counter 0. An in-flight transfer is aborted with no ack.

## Timing
- Request first visible in IDLE cycle t:
  - `mem_en` in cycle t+1;
  - `mem_rdata` sampled at the end of cycle t+1+`MEM_LAT`;
  - ack and valid rdata in cycle t+2+`MEM_LAT`.
- Back-to-back transfers: `mem_en` pulses at least `MEM_LAT`+3 cycles apart.
- `if_ack` and `d_ack` are never high in the same cycle.
- `busy` = 0 only in IDLE.

## Configuration
- `MEM_ARB_STARVE_EN` defined: a saturating counter counts data grants issued while `if_req` was also high.
  - When the count equals `STARVE_MAX`, the next contested arbitration grants fetch.
  - The counter clears on any fetch grant, or on a data grant with `if_req` low.
- `MEM_ARB_STARVE_EN` not defined: strict data priority; no counter is present.

## Test plan
- `MEM_LAT`=2, `if_req` with `if_addr`=0x100 first seen in cycle 0, `mem_rdata`=0xDEADBEEF valid in cycle 3 -> response:
  - cycle 1: `mem_en`=1, `mem_we`=0, `mem_addr`=0x100, `sel`=0;
  - cycle 4: `if_ack`=1, `if_rdata`=0xDEADBEEF.
- `if_req` and `d_req` (read) both high in cycle 0 -> `sel`=1 and `mem_en` in cycle 1, `d_ack` in cycle 4; fetch `mem_en` in cycle 6, `if_ack` in cycle 9.
- Write: `d_we`=1, `d_addr`=0x2000, `d_wdata`=0x1234 -> in the ISSUE cycle `mem_we`=1, `mem_wdata`=0x1234; `d_ack` after `MEM_LAT`+1 further cycles; `d_rdata` unchanged.
- Both requests held high for 10 grants, `STARVE_MAX`=4 -> grant order D,D,D,D,F,D,D,D,D,F with the macro; all D without it.
- `rst_n` pulsed low during WAIT -> no ack, all outputs 0 immediately, state IDLE; a request after release completes normally with the latency above.
- `d_addr` changed from 0x40 to 0x80 during WAIT, and `d_req` kept high through DONE then dropped -> `mem_addr` stays 0x40, and no second transfer starts.
